// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus between the PC sequencer, instruction memory, hazard unit and IF/ID.
interface fetch_unit_if;
  logic        StallF, JumpD, BranchTakenD, IMReady;
  logic [31:0] JumpTargetD, BranchTargetD, IMRD;
  logic [31:0] PCF, InstrF, PCp1F;
  logic        IMReq, StallD, CLRD;
  modport master (
    input  StallF, JumpD, JumpTargetD, BranchTakenD, BranchTargetD, IMReady, IMRD,
    output PCF, IMReq, InstrF, PCp1F, StallD, CLRD
  );
  modport slave (
    output StallF, JumpD, JumpTargetD, BranchTakenD, BranchTargetD, IMReady, IMRD,
    input  PCF, IMReq, InstrF, PCp1F, StallD, CLRD
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: word-addressed PC sequencer with a one-entry hold buffer and decode-stage redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input logic         CLK,
  input logic         CLR,
  fetch_unit_if.master f
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      state, state_n;
  logic [31:0] pc, pc_n, pcp1, hold_instr, hold_instr_n, hold_pcp1, hold_pcp1_n;
  logic        held, redirect, deliver, capture;
  assign pcp1     = pc + 32'd1;
  assign held     = state == HOLD;
  assign redirect = f.JumpD | f.BranchTakenD;
  assign deliver  = !redirect && !f.StallF && (held || f.IMReady);
  assign capture  = !redirect && !held && f.IMReady && f.StallF;
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_instr <= '0;
      hold_pcp1  <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      hold_instr <= hold_instr_n;
      hold_pcp1  <= hold_pcp1_n;
    end
  end
  always_comb begin
    state_n      = (capture || (held && !redirect && f.StallF)) ? HOLD : FETCH;
    pc_n         = redirect ? (f.JumpD ? f.JumpTargetD : f.BranchTargetD) : deliver ? pcp1 : pc;
    hold_instr_n = redirect ? '0 : capture ? f.IMRD : hold_instr;
    hold_pcp1_n  = redirect ? '0 : capture ? pcp1 : hold_pcp1;
  end
  // Reset overrides the delivery/flush strobes so IF/ID only ever sees a bubble during CLR.
  always_comb begin
    f.PCF    = pc;
    f.IMReq  = !held;
    f.InstrF = held ? hold_instr : f.IMRD;
    f.PCp1F  = held ? hold_pcp1 : pcp1;
    f.StallD = CLR || !deliver;
    f.CLRD   = redirect && !CLR;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of sequencing, memory wait, hold buffer, redirects, wrap and async reset.
module tb_fetch_unit;
  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int   checks = 0;
  int   errors = 0;
  fetch_unit_if f();
  fetch_unit #(.RESET_PC(32'h00000000)) dut (.CLK(CLK), .CLR(CLR), .f(f));
  always #5 CLK = ~CLK;

  task automatic idle();
    f.StallF = 0; f.JumpD = 0; f.BranchTakenD = 0; f.IMReady = 0;
    f.JumpTargetD = '0; f.BranchTargetD = '0; f.IMRD = '0;
  endtask

  task automatic test_reset();
    idle();
    #1 CLR = 1'b1;
    f.IMReady = 1; f.JumpD = 1; f.IMRD = 32'hAAAA0000;
    #1;
    checks++;
    if ({f.PCF, f.PCp1F} !== {32'd0, 32'd1}) begin
      errors++; $display("FAIL reset_pc PCF=%h PCp1F=%h want 0/1", f.PCF, f.PCp1F);
    end
    checks++;
    if ({f.IMReq, f.StallD, f.CLRD} !== 3'b110 || f.InstrF !== 32'hAAAA0000) begin
      errors++; $display("FAIL reset_ctl req/stall/clr=%b InstrF=%h want 110/aaaa0000", {f.IMReq, f.StallD, f.CLRD}, f.InstrF);
    end
    f.JumpD = 0;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      f.IMReady = 1; f.StallF = 0; f.IMRD = 32'h100 + i;
      #1;
      checks++;
      if (f.PCF !== i || f.PCp1F !== i + 1 || f.StallD !== 1'b0 || f.InstrF !== 32'h100 + i) begin
        errors++; $display("FAIL seq%0d PCF=%h PCp1F=%h StallD=%b InstrF=%h want %h/%h/0", i, f.PCF, f.PCp1F, f.StallD, f.InstrF, i, i + 1);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_mem_wait();
    f.JumpD = 1; f.JumpTargetD = 32'd5;
    #1;
    checks++;
    if ({f.CLRD, f.StallD} !== 2'b11) begin
      errors++; $display("FAIL jump_flush CLRD/StallD=%b want 11", {f.CLRD, f.StallD});
    end
    @(negedge CLK);
    f.JumpD = 0; f.IMReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (f.PCF !== 32'd5 || {f.IMReq, f.StallD} !== 2'b11) begin
        errors++; $display("FAIL wait%0d PCF=%h req/stall=%b want 5/11", i, f.PCF, {f.IMReq, f.StallD});
      end
      @(negedge CLK);
    end
    f.IMReady = 1; f.IMRD = 32'h55;
    #1;
    checks++;
    if (f.StallD !== 1'b0 || f.PCp1F !== 32'd6 || f.InstrF !== 32'h55) begin
      errors++; $display("FAIL wait_deliver StallD=%b PCp1F=%h InstrF=%h want 0/6/55", f.StallD, f.PCp1F, f.InstrF);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (f.PCF !== 32'd6) begin
      errors++; $display("FAIL wait_next PCF=%h want 6", f.PCF);
    end
  endtask

  task automatic test_hold();
    f.JumpD = 1; f.JumpTargetD = 32'd8;
    @(negedge CLK);
    f.JumpD = 0; f.IMReady = 1; f.StallF = 1; f.IMRD = 32'hDEAD0008;
    #1;
    checks++;
    if (f.PCF !== 32'd8 || {f.IMReq, f.StallD} !== 2'b11) begin
      errors++; $display("FAIL hold_capture PCF=%h req/stall=%b want 8/11", f.PCF, {f.IMReq, f.StallD});
    end
    @(negedge CLK);
    f.IMReady = 0; f.IMRD = 32'hFFFFFFFF;
    #1;
    checks++;
    if (f.IMReq !== 1'b0 || f.StallD !== 1'b1 || f.InstrF !== 32'hDEAD0008 || f.PCF !== 32'd8) begin
      errors++; $display("FAIL hold_stay IMReq=%b StallD=%b InstrF=%h PCF=%h want 0/1/dead0008/8", f.IMReq, f.StallD, f.InstrF, f.PCF);
    end
    @(negedge CLK);
    f.StallF = 0;
    #1;
    checks++;
    if (f.StallD !== 1'b0 || f.InstrF !== 32'hDEAD0008 || f.PCp1F !== 32'd9) begin
      errors++; $display("FAIL hold_deliver StallD=%b InstrF=%h PCp1F=%h want 0/dead0008/9", f.StallD, f.InstrF, f.PCp1F);
    end
    @(negedge CLK);
    f.IMReady = 1; f.StallF = 1; f.IMRD = 32'hBEEF0009;
    #1;
    checks++;
    if (f.PCF !== 32'd9 || f.IMReq !== 1'b1) begin
      errors++; $display("FAIL hold_next PCF=%h IMReq=%b want 9/1", f.PCF, f.IMReq);
    end
    @(negedge CLK);
  endtask

  task automatic test_redirect_hold();
    f.BranchTakenD = 1; f.BranchTargetD = 32'h40; f.StallF = 0; f.IMReady = 1; f.IMRD = 32'h1234;
    #1;
    checks++;
    if ({f.IMReq, f.CLRD, f.StallD} !== 3'b011) begin
      errors++; $display("FAIL branch_in_hold req/clr/stall=%b want 011", {f.IMReq, f.CLRD, f.StallD});
    end
    @(negedge CLK);
    f.BranchTakenD = 0; f.IMReady = 0;
    #1;
    checks++;
    if (f.PCF !== 32'h40 || f.IMReq !== 1'b1 || f.InstrF !== 32'h1234 || f.StallD !== 1'b1) begin
      errors++; $display("FAIL branch_target PCF=%h IMReq=%b InstrF=%h StallD=%b want 40/1/1234/1", f.PCF, f.IMReq, f.InstrF, f.StallD);
    end
    @(negedge CLK);
  endtask

  task automatic test_jump_priority();
    f.JumpD = 1; f.JumpTargetD = 32'h100; f.BranchTakenD = 1; f.BranchTargetD = 32'h200;
    #1;
    checks++;
    if (f.CLRD !== 1'b1) begin
      errors++; $display("FAIL prio_clr CLRD=%b want 1", f.CLRD);
    end
    @(negedge CLK);
    f.JumpD = 0; f.BranchTakenD = 0;
    #1;
    checks++;
    if (f.PCF !== 32'h100) begin
      errors++; $display("FAIL prio_target PCF=%h want 100", f.PCF);
    end
  endtask

  task automatic test_back_to_back();
    f.JumpD = 1; f.JumpTargetD = 32'h100;
    #1;
    checks++;
    if ({f.CLRD, f.StallD} !== 2'b11) begin
      errors++; $display("FAIL same_pc_flush CLRD/StallD=%b want 11", {f.CLRD, f.StallD});
    end
    @(negedge CLK);
    f.JumpD = 0; f.BranchTakenD = 1; f.BranchTargetD = 32'h30; f.IMReady = 1;
    #1;
    checks++;
    if (f.PCF !== 32'h100 || {f.CLRD, f.StallD} !== 2'b11) begin
      errors++; $display("FAIL b2b_first PCF=%h CLRD/StallD=%b want 100/11", f.PCF, {f.CLRD, f.StallD});
    end
    @(negedge CLK);
    f.BranchTakenD = 0; f.JumpD = 1; f.JumpTargetD = 32'h20;
    #1;
    checks++;
    if (f.PCF !== 32'h30 || f.CLRD !== 1'b1) begin
      errors++; $display("FAIL b2b_second PCF=%h CLRD=%b want 30/1", f.PCF, f.CLRD);
    end
    @(negedge CLK);
    f.JumpD = 0; f.IMReady = 0;
    #1;
    checks++;
    if (f.PCF !== 32'h20 || f.CLRD !== 1'b0) begin
      errors++; $display("FAIL b2b_third PCF=%h CLRD=%b want 20/0", f.PCF, f.CLRD);
    end
  endtask

  task automatic test_wrap();
    f.JumpD = 1; f.JumpTargetD = 32'hFFFFFFFF;
    @(negedge CLK);
    f.JumpD = 0; f.IMReady = 1; f.StallF = 0;
    #1;
    checks++;
    if (f.PCF !== 32'hFFFFFFFF || f.PCp1F !== 32'd0 || f.StallD !== 1'b0) begin
      errors++; $display("FAIL wrap_deliver PCF=%h PCp1F=%h StallD=%b want ffffffff/0/0", f.PCF, f.PCp1F, f.StallD);
    end
    @(negedge CLK);
    f.IMReady = 0;
    #1;
    checks++;
    if (f.PCF !== 32'd0) begin
      errors++; $display("FAIL wrap_next PCF=%h want 0", f.PCF);
    end
  endtask

  task automatic test_clr_in_hold();
    f.JumpD = 1; f.JumpTargetD = 32'h77;
    @(negedge CLK);
    f.JumpD = 0; f.IMReady = 1; f.StallF = 1; f.IMRD = 32'hC0DE;
    @(negedge CLK);
    f.IMReady = 0;
    #1;
    checks++;
    if (f.IMReq !== 1'b0 || f.PCF !== 32'h77) begin
      errors++; $display("FAIL clr_pre IMReq=%b PCF=%h want 0/77", f.IMReq, f.PCF);
    end
    #1 CLR = 1'b1;
    #1;
    checks++;
    if (f.PCF !== 32'd0 || f.IMReq !== 1'b1 || f.StallD !== 1'b1 || f.CLRD !== 1'b0) begin
      errors++; $display("FAIL clr_async PCF=%h IMReq=%b StallD=%b CLRD=%b want 0/1/1/0", f.PCF, f.IMReq, f.StallD, f.CLRD);
    end
    @(negedge CLK);
    CLR = 1'b0; f.IMReady = 1; f.StallF = 0; f.IMRD = 32'hF00D;
    #1;
    checks++;
    if (f.PCF !== 32'd0 || f.InstrF !== 32'hF00D || f.StallD !== 1'b0 || f.IMReq !== 1'b1) begin
      errors++; $display("FAIL clr_after PCF=%h InstrF=%h StallD=%b IMReq=%b want 0/f00d/0/1", f.PCF, f.InstrF, f.StallD, f.IMReq);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_mem_wait();
    test_hold();
    test_redirect_hold();
    test_jump_priority();
    test_back_to_back();
    test_wrap();
    test_clr_in_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 CLK  input  1  rising-edge clock; sole clock of the block.
REQ-003 CLR  input  1  reset; asynchronous, active-high.
REQ-004 StallF  input  1  hazard-unit stall; 1 = decode cannot accept a new instruction this cycle.
REQ-005 JumpD  input  1  jump resolved in decode; redirect to JumpTargetD.
REQ-006 JumpTargetD  input  32  jump target, word address.
REQ-007 BranchTakenD  input  1  taken branch resolved in decode; redirect to BranchTargetD.
REQ-008 BranchTargetD  input  32  branch target, word address.
REQ-009 IMReady  input  1  instruction memory returns valid IMRD for current PCF this cycle.
REQ-010 IMRD  input  32  instruction memory read data.
REQ-011 PCF  output  32  current fetch PC; instruction memory address.
REQ-012 IMReq  output  1  instruction memory read request.
REQ-013 InstrF  output  32  instruction presented to IF/ID register.
REQ-014 PCp1F  output  32  PC+1 of the presented instruction, to IF/ID register.
REQ-015 StallD  output  1  drives IF/ID Stall; 1 = IF/ID loads a bubble (zeros).
REQ-016 CLRD  output  1  drives IF/ID CLR; 1 = flush wrong-path instruction.

Function
REQ-017 PC register SHALL be word-addressed; PC+1 SHALL wrap modulo 2^32 (32'hFFFFFFFF+1 = 0).
REQ-018 States SHALL be FETCH and HOLD only; reset state FETCH.
REQ-019 FETCH: IMReq=1, PCF=PC, InstrF=IMRD, PCp1F=PC+1.
REQ-020 FETCH, IMReady=1, StallF=0, no redirect: StallD=0; PC<=PC+1 at edge; stay FETCH.
REQ-021 FETCH, IMReady=1, StallF=1, no redirect: StallD=1; IMRD and PC+1 captured into hold registers; PC unchanged; go HOLD.
REQ-022 FETCH, IMReady=0, no redirect: StallD=1; PC unchanged; stay FETCH (request stays asserted at same address).
REQ-023 HOLD: IMReq=0; InstrF and PCp1F driven from hold registers; PCF=PC.
REQ-024 HOLD, StallF=1, no redirect: StallD=1; stay HOLD; hold registers unchanged.
REQ-025 HOLD, StallF=0, no redirect: StallD=0; PC<=PC+1; go FETCH.
REQ-026 Redirect = JumpD or BranchTakenD; redirect SHALL take priority over StallF and IMReady in either state.
REQ-027 JumpD and BranchTakenD both 1: JumpTargetD SHALL win.
REQ-028 Redirect cycle: CLRD=1 and StallD=1 combinationally; PC<=selected target at edge; hold registers cleared; next state FETCH; any in-flight or held instruction discarded.
REQ-029 CLRD SHALL be 1 only in redirect cycles; StallD SHALL be 0 only in the delivery cycles of REQ-020/REQ-025.
REQ-030 Redirect to target equal to current PC SHALL still flush and refetch.
REQ-031 Back-to-back redirects on consecutive cycles SHALL each flush and each load its own target.
REQ-032 No combinational path from IMRD to IMReq or PCF.

Reset
REQ-033 CLR=1 SHALL immediately force PC=RESET_PC, state FETCH, hold registers 0, independent of CLK.
REQ-034 While CLR=1: PCF=RESET_PC, IMReq=1, StallD=1, CLRD=0, InstrF=IMRD, PCp1F=RESET_PC+1.
REQ-035 First PC update SHALL occur at the first rising CLK edge with CLR=0.
REQ-036 CLR asserted in HOLD or mid-wait SHALL discard the held/pending instruction with no delivery.

Verification
REQ-037 Reset then IMReady=1, StallF=0 for 4 cycles -> PCF 0,1,2,3; PCp1F 1,2,3,4; StallD=0 each cycle.
REQ-038 PC=5, IMReady=0 for 3 cycles then 1 -> PCF=5 held, StallD=1 three cycles, delivery with PCp1F=6.
REQ-039 PC=8, IMReady=1, StallF=1 for 2 cycles then 0 -> HOLD entered, IMReq=0, InstrF=buffered word, delivered with PCp1F=9, next PCF=9.
REQ-040 In HOLD, BranchTakenD=1, BranchTargetD=32'h40 -> CLRD=1, StallD=1, next PCF=32'h40, buffered word never delivered.
REQ-041 JumpD=1 (target 32'h100) and BranchTakenD=1 (target 32'h200) same cycle -> next PCF=32'h100.
REQ-042 PC=32'hFFFFFFFF delivered -> PCp1F=0, next PCF=0; CLR pulsed mid-cycle in HOLD -> PCF=RESET_PC without a clock edge.
